// File: rtl/bus_uart_if.sv
// Bus-side port bundle of the UART: hub-style request signals in,
// combinational decode plus registered ready/rdata back.
interface bus_uart_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        ren;
    logic        wen;
    logic [31:0] rdata;
    logic        ready;
    logic        active;

    modport master (output addr, wdata, wmask, ren, wen,
                    input  rdata, ready, active);
    modport slave  (input  addr, wdata, wmask, ren, wen,
                    output rdata, ready, active);
endinterface

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART: DATA/STATUS/DIV registers, TX and RX byte FIFOs,
// bit-serial TX/RX state machines sharing one programmable divisor.
module bus_uart #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter logic [15:0] DEFAULT_DIV = 16'd433,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic      clk,
    input  logic      rst,
    bus_uart_if.slave bus,
    output logic      tx,
    input  logic      rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

    // ---------------- bus decode ----------------
    logic [31:0] off;
    logic        acc, wr_acc, rd_acc;
    logic [1:0]  sel;

    // subtract-then-compare stays correct even if BASE_ADDR sits near the top
    assign off        = bus.addr - BASE_ADDR;
    assign bus.active = (off < 32'd16);
    assign acc        = (bus.ren | bus.wen) & bus.active & ~bus.ready;
    assign wr_acc     = acc & bus.wen;
    assign rd_acc     = acc & bus.ren & ~bus.wen;
    assign sel        = bus.addr[3:2];

    logic unused_bits;
    assign unused_bits = ^{bus.wdata[31:16], bus.wmask[3:2], bus.addr[1:0]};

    logic [15:0] div;
    logic [2:0]  sticky;   // {frame_err, rx_ovf, tx_ovf}

    // ---------------- TX FIFO ----------------
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp;
    logic        tx_full, tx_empty, tx_wr, tx_push, tx_pop;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_wr    = wr_acc && (sel == 2'd0) && bus.wmask[0];
    assign tx_push  = tx_wr && (!tx_full || tx_pop);

    // ---------------- RX FIFO ----------------
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wp, rx_rp;
    logic        rx_full, rx_empty, rx_push, rx_pop;
    logic        rx_stop, rx_good;
    logic [7:0]  rx_sh;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_pop   = rd_acc && (sel == 2'd0) && !rx_empty;
    assign rx_push  = rx_good && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.wdata[7:0];
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
        end
    end

    // ---------------- TX FSM ----------------
    uart_st_e    tx_st;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_busy;

    assign tx_pop  = !tx_empty && ((tx_st == S_IDLE) || ((tx_st == S_STOP) && (tx_cnt == 16'd0)));
    assign tx_busy = (tx_st != S_IDLE) || !tx_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st  <= S_IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            tx     <= 1'b1;
        end else begin
            case (tx_st)
                S_IDLE: if (tx_pop) begin
                    tx_sh  <= tx_mem[tx_rp[AW-1:0]];
                    tx_cnt <= div;
                    tx     <= 1'b0;
                    tx_st  <= S_START;
                end
                S_START: if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
                else begin
                    tx_cnt <= div;
                    tx_bit <= '0;
                    tx     <= tx_sh[0];
                    tx_st  <= S_DATA;
                end
                S_DATA: if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
                else begin
                    tx_cnt <= div;
                    if (tx_bit == 3'd7) begin
                        tx    <= 1'b1;
                        tx_st <= S_STOP;
                    end else begin
                        tx_bit <= tx_bit + 3'd1;
                        tx_sh  <= {1'b0, tx_sh[7:1]};
                        tx     <= tx_sh[1];
                    end
                end
                S_STOP: if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
                // back-to-back bytes go straight into the next start bit
                else if (tx_pop) begin
                    tx_sh  <= tx_mem[tx_rp[AW-1:0]];
                    tx_cnt <= div;
                    tx     <= 1'b0;
                    tx_st  <= S_START;
                end else begin
                    tx_st <= S_IDLE;
                end
                default: tx_st <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FSM ----------------
    uart_st_e    rx_st;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic        rx_s1, rx_s2, rx_prev;

    assign rx_stop = (rx_st == S_STOP) && (rx_cnt == 16'd0);
    assign rx_good = rx_stop && rx_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            rx_st   <= S_IDLE;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            case (rx_st)
                // half-bit wait lands every later sample near mid-bit
                S_IDLE: if (rx_prev && !rx_s2) begin
                    rx_cnt <= div >> 1;
                    rx_st  <= S_START;
                end
                S_START: if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
                else if (rx_s2) rx_st <= S_IDLE;
                else begin
                    rx_cnt <= div;
                    rx_bit <= '0;
                    rx_st  <= S_DATA;
                end
                S_DATA: if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
                else begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_cnt <= div;
                    if (rx_bit == 3'd7) rx_st <= S_STOP;
                    else                rx_bit <= rx_bit + 3'd1;
                end
                S_STOP: if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
                else rx_st <= S_IDLE;
                default: rx_st <= S_IDLE;
            endcase
        end
    end

    // ---------------- registers ----------------
    logic [2:0]  st_set, st_clr;
    logic [31:0] status, rd_val;

    assign st_set = {rx_stop && !rx_s2, rx_good && !rx_push, tx_wr && !tx_push};
    assign st_clr = (wr_acc && (sel == 2'd1) && bus.wmask[0]) ? bus.wdata[7:5] : 3'b000;
    assign status = {24'b0, sticky, tx_busy, rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        rd_val = '0;
        case (sel)
            2'd0:    if (!rx_empty) rd_val = {23'b0, 1'b1, rx_mem[rx_rp[AW-1:0]]};
            2'd1:    rd_val = status;
            2'd2:    rd_val = {16'b0, div};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div        <= DEFAULT_DIV;
            sticky     <= '0;
            bus.ready  <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            // a flag raised in the same cycle as its clear stays set
            sticky    <= (sticky & ~st_clr) | st_set;
            bus.ready <= acc;
            bus.rdata <= rd_acc ? rd_val : 32'b0;
            if (wr_acc && (sel == 2'd2)) begin
                if (bus.wmask[0]) div[7:0]  <= bus.wdata[7:0];
                if (bus.wmask[1]) div[15:8] <= bus.wdata[15:8];
            end
        end
    end
endmodule

// File: tb/tb_bus_uart.sv
// Randomized scoreboard bench for bus_uart: bus responses and decoded serial
// frames are checked against a queue-based model of the register block.
module tb_bus_uart;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          FD   = 8;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic rx_drv, loop;
    logic rx_pin;

    bus_uart_if bif();
    assign rx_pin = loop ? tx : rx_drv;

    bus_uart #(.BASE_ADDR(BASE), .DEFAULT_DIV(16'd433), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .bus(bif), .tx(tx), .rx(rx_pin));

    always #5 clk = ~clk;

    typedef struct { logic [31:0] mask; logic [31:0] val; string nm; } exp_t;
    exp_t       sbq[$];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int         tx_starts[$];
    int         n_cmp = 0, n_err = 0;
    int         cyc = 0, cur_div = 433, rst_gen = 0;
    logic       ferr = 1'b0, rovf = 1'b0, tovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Status as the register map defines it, valid whenever TX is idle.
    function automatic logic [31:0] exp_status();
        return {24'b0, ferr, rovf, tovf, 1'b0, rxq.size() == FD, rxq.size() == 0, 1'b1, 1'b0};
    endfunction

    // One bus access; the expected response is queued for the monitor.
    task automatic bus(input logic w, input logic r, input logic [3:0] offs,
                       input logic [31:0] d, input logic [3:0] m,
                       input logic [31:0] emask, input logic [31:0] eval, input string nm);
        exp_t e;
        e.mask = emask; e.val = eval; e.nm = nm;
        sbq.push_back(e);
        @(posedge clk); #1;
        bif.addr = BASE + {28'b0, offs}; bif.wdata = d; bif.wmask = m;
        bif.wen = w; bif.ren = r;
        @(posedge clk); #1;
        bif.wen = 1'b0; bif.ren = 1'b0;
    endtask

    task automatic wr(input logic [3:0] offs, input logic [31:0] d, input logic [3:0] m);
        bus(1'b1, 1'b0, offs, d, m, 32'h0, 32'h0, "write");
    endtask

    task automatic rd(input logic [3:0] offs, input logic [31:0] emask,
                      input logic [31:0] eval, input string nm);
        bus(1'b0, 1'b1, offs, 32'h0, 4'h0, emask, eval, nm);
    endtask

    task automatic set_div(input int d);
        wr(4'h8, d, 4'b0011);
        cur_div = d;
    endtask

    task automatic wait_tx(input int maxc);
        int c = 0;
        while (txq.size() != 0 && c < maxc) begin @(posedge clk); c++; end
        n_cmp++;
        if (txq.size() != 0) begin
            n_err++;
            $display("FAIL tx_timeout: %0d bytes still expected on tx, want 0", txq.size());
            txq.delete();
        end
        repeat (cur_div + 10) @(posedge clk);
    endtask

    task automatic check_gaps(input int n);
        chk("tx_frame_count", tx_starts.size(), n);
        for (int i = 1; i < tx_starts.size(); i++)
            chk("tx_frame_gap", tx_starts[i] - tx_starts[i-1], 10 * (cur_div + 1));
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 rx_drv = f[i];
            repeat (cur_div) @(posedge clk);
        end
        @(posedge clk); #1 rx_drv = 1'b1;
        repeat (cur_div + 8) @(posedge clk);
    endtask

    // Bus monitor: every ready pulse must match the oldest outstanding access.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bif.ready === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_ready: ready=1 rdata=%h, expected no response", bif.rdata);
                end else begin
                    e = sbq.pop_front();
                    chk(e.nm, bif.rdata & e.mask, e.val);
                end
            end
        end
    end

    // Serial monitor: decode 8N1 frames on tx by mid-bit sampling.
    initial begin
        logic       last, ok;
        logic [7:0] b, e;
        int         d, g, st;
        last = 1'b1;
        forever begin
            @(negedge clk);
            if (last === 1'b1 && tx === 1'b0 && !rst) begin
                d = cur_div; g = rst_gen; st = cyc;
                repeat ((d + 1) / 2) @(negedge clk);
                ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (d + 1) @(negedge clk);
                    b[i] = tx;
                end
                repeat (d + 1) @(negedge clk);
                ok = ok && (tx === 1'b1);
                if (g == rst_gen) begin
                    tx_starts.push_back(st);
                    chk("tx_framing", {31'b0, ok}, 32'h1);
                    if (txq.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL tx_unexpected: byte %h on tx, expected none", b);
                    end else begin
                        e = txq.pop_front();
                        chk("tx_byte", {24'b0, b}, {24'b0, e});
                    end
                end
            end
            last = tx;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1; loop = 1'b0; rx_drv = 1'b1;
        bif.addr = '0; bif.wdata = '0; bif.wmask = '0; bif.ren = 1'b0; bif.wen = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_tx", {31'b0, tx}, 32'h1);
        chk("rst_ready", {31'b0, bif.ready}, 32'h0);
        chk("rst_rdata", bif.rdata, 32'h0);
        rst = 1'b0;
        rd(4'h4, '1, 32'h06, "rst_status");
        rd(4'h8, '1, 32'd433, "rst_div");

        // divisor byte lanes
        set_div(3);
        rd(4'h8, '1, 32'd3, "div_rw");
        wr(4'h8, 32'hFFFF_5A77, 4'b0010);
        rd(4'h8, '1, 32'h5A03, "div_lane1");
        set_div(3);

        // single frame
        tx_starts.delete();
        txq.push_back(8'hA5);
        wr(4'h0, 32'hA5, 4'h1);
        rd(4'h4, 32'h10, 32'h10, "busy_in_frame");
        wait_tx(200);
        rd(4'h4, '1, exp_status(), "status_after_tx");

        // random divisors, short bursts
        for (int r = 0; r < 3; r++) begin
            set_div($urandom_range(3, 7));
            tx_starts.delete();
            for (int i = 0; i < 3; i++) begin
                b = 8'($urandom);
                txq.push_back(b);
                wr(4'h0, {24'b0, b}, 4'h1);
            end
            wait_tx(400);
            check_gaps(3);
        end

        // overflow: one byte in flight + FIFO_DEPTH queued, the rest dropped
        set_div(3);
        tx_starts.delete();
        for (int i = 0; i < FD + 2; i++) begin
            b = 8'($urandom);
            if (i < FD + 1) txq.push_back(b);
            wr(4'h0, {24'b0, b}, 4'h1);
        end
        tovf = 1'b1;
        wait_tx(600);
        check_gaps(FD + 1);
        rd(4'h4, '1, exp_status(), "tx_ovf_status");
        wr(4'h4, 32'h20, 4'h1);
        tovf = 1'b0;
        rd(4'h4, '1, exp_status(), "tx_ovf_clr");

        // loopback
        loop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'h3C : 8'($urandom);
            txq.push_back(b);
            wr(4'h0, {24'b0, b}, 4'h1);
            wait_tx(200);
            rd(4'h0, '1, {23'b0, 1'b1, b}, "loop_rd");
            rd(4'h0, '1, 32'h0, "loop_rd_empty");
        end
        loop = 1'b0;

        // framing error and glitch
        set_div($urandom_range(3, 7));
        send_rx(8'($urandom), 1'b0);
        ferr = 1'b1;
        rd(4'h4, '1, exp_status(), "ferr_status");
        wr(4'h4, 32'h80, 4'h1);
        ferr = 1'b0;
        rd(4'h4, '1, exp_status(), "ferr_clr");
        @(posedge clk); #1 rx_drv = 1'b0;
        @(posedge clk); #1 rx_drv = 1'b1;
        repeat (20) @(posedge clk);
        rd(4'h4, '1, exp_status(), "glitch_status");
        rd(4'h0, '1, 32'h0, "glitch_no_byte");

        // RX overflow
        for (int i = 0; i < FD + 1; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            if (rxq.size() < FD) rxq.push_back(b);
            else                 rovf = 1'b1;
        end
        rd(4'h4, '1, exp_status(), "rx_ovf_status");
        while (rxq.size() != 0) rd(4'h0, '1, {23'b0, 1'b1, rxq.pop_front()}, "rx_ovf_rd");
        rd(4'h0, '1, 32'h0, "rx_drained");
        wr(4'h4, 32'h40, 4'h1);
        rovf = 1'b0;
        rd(4'h4, '1, exp_status(), "rx_ovf_clr");

        // held read: two accepts in four cycles
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            rxq.push_back(b);
        end
        begin
            exp_t e;
            for (int i = 0; i < 2; i++) begin
                e.mask = '1; e.val = {23'b0, 1'b1, rxq.pop_front()}; e.nm = "held_rd";
                sbq.push_back(e);
            end
        end
        @(posedge clk); #1 bif.addr = BASE; bif.ren = 1'b1;
        repeat (4) @(posedge clk);
        #1 bif.ren = 1'b0;

        // write+read together is a write only
        b = 8'($urandom);
        txq.push_back(b);
        bus(1'b1, 1'b1, 4'h0, {24'b0, b}, 4'h1, 32'h0, 32'h0, "wr_rd_write");
        rd(4'h0, '1, {23'b0, 1'b1, rxq.pop_front()}, "wr_rd_no_pop");
        wait_tx(200);

        // address window edges
        @(posedge clk); #1 bif.addr = BASE + 32'd16; bif.ren = 1'b1;
        #1 chk("active_above", {31'b0, bif.active}, 32'h0);
        repeat (3) @(posedge clk);
        #1 bif.addr = BASE - 32'd4;
        #1 chk("active_below", {31'b0, bif.active}, 32'h0);
        repeat (2) @(posedge clk);
        #1 bif.ren = 1'b0; bif.addr = BASE + 32'd12;
        #1 chk("active_top", {31'b0, bif.active}, 32'h1);
        wr(4'hC, 32'hFFFF_FFFF, 4'hF);
        rd(4'hC, '1, 32'h0, "reg_c_zero");
        rd(4'h4, '1, exp_status(), "reg_c_no_effect");

        // reset in the middle of a frame
        wr(4'h0, 32'h00, 4'h1);
        repeat (8) @(posedge clk); #1;
        chk("tx_low_midframe", {31'b0, tx}, 32'h0);
        rst_gen++;
        rst = 1'b1;
        #1 chk("rst_midframe_tx", {31'b0, tx}, 32'h1);
        @(posedge clk); #1 rst = 1'b0;
        cur_div = 433;
        rd(4'h4, '1, 32'h06, "rst2_status");
        rd(4'h8, '1, 32'd433, "rst2_div");

        repeat (60) @(posedge clk);
        chk("sb_drained", sbq.size(), 32'h0);
        chk("txq_drained", txq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
